bch_enc_frame_ctrl: RTL and testbench

//   Frame sequencer for the 4-bit-parallel BCH(511,484) encoder core. Accepts message nibbles on a

---
 rtl/bch_enc_frame_ctrl.sv | 117 +++++++++++
 tb/tb_bch_enc_frame_ctrl.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bch_enc_frame_ctrl.sv
// Frame sequencer for the 4-bit-parallel BCH(511,484) encoder: clears the encoder, streams the
// message through it, then appends the captured parity as MSB-first nibbles.
module bch_enc_frame_ctrl #(
    parameter int unsigned P         = 4,
    parameter int unsigned MSG_BEATS = 121,
    parameter int unsigned PAR_BITS  = 27,
    parameter int unsigned PAR_BEATS = 7
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [P-1:0]        s_data,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [P-1:0]        m_data,
    output logic                m_last,
    output logic                m_is_par,
    output logic                enc_clr,
    output logic                enc_en,
    output logic [P-1:0]        enc_msg,
    input  logic [PAR_BITS-1:0] enc_parity,
    output logic                busy,
    output logic [15:0]         frame_cnt
);

    localparam int unsigned SrW  = PAR_BEATS * P;
    localparam int unsigned CntW = (MSG_BEATS > PAR_BEATS) ? $clog2(MSG_BEATS) : $clog2(PAR_BEATS);

    localparam logic [2:0] StIdle = 3'd0;
    localparam logic [2:0] StClr  = 3'd1;
    localparam logic [2:0] StMsg  = 3'd2;
    localparam logic [2:0] StLoad = 3'd3;
    localparam logic [2:0] StPar  = 3'd4;

    logic [2:0]      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [SrW-1:0]  sr_q, sr_d;
    logic [15:0]     frame_cnt_q, frame_cnt_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sr_d        = sr_q;
        frame_cnt_d = frame_cnt_q;
        s_ready     = 1'b0;
        m_valid     = 1'b0;
        m_data      = '0;
        m_last      = 1'b0;
        m_is_par    = 1'b0;
        enc_clr     = 1'b0;
        enc_en      = 1'b0;

        case (state_q)
            StIdle: begin
                // The waiting nibble stays upstream; it is consumed only in MSG.
                if (s_valid) state_d = StClr;
            end
            StClr: begin
                enc_clr = 1'b1;
                cnt_d   = '0;
                state_d = StMsg;
            end
            StMsg: begin
                s_ready = m_ready;
                m_valid = s_valid;
                m_data  = s_data;
                enc_en  = s_valid & m_ready;
                if (enc_en) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CntW'(MSG_BEATS - 1)) state_d = StLoad;
                end
            end
            StLoad: begin
                // Encoder register has settled one edge after the last enc_en.
                sr_d                 = '0;
                sr_d[PAR_BITS-1:0]   = enc_parity;
                cnt_d                = '0;
                state_d              = StPar;
            end
            StPar: begin
                m_valid  = 1'b1;
                m_is_par = 1'b1;
                m_data   = sr_q[SrW-1 -: P];
                m_last   = (cnt_q == CntW'(PAR_BEATS - 1));
                if (m_ready) begin
                    sr_d  = sr_q << P;
                    cnt_d = cnt_q + 1'b1;
                    if (m_last) begin
                        frame_cnt_d = frame_cnt_q + 16'd1;
                        state_d     = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            sr_q        <= '0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sr_q        <= sr_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign enc_msg   = s_data;
    assign busy      = (state_q != StIdle);
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_bch_enc_frame_ctrl.sv
// Directed bench for bch_enc_frame_ctrl with a behavioural 4-bit-parallel BCH(511,484) encoder.
module tb_bch_enc_frame_ctrl;

    localparam logic [26:0] GPoly  = 27'h5612B79;
    localparam logic [27:0] ParOne = 28'h5612B79;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid, s_ready;
    logic [3:0]  s_data;
    logic        m_valid, m_ready;
    logic [3:0]  m_data;
    logic        m_last, m_is_par;
    logic        enc_clr, enc_en;
    logic [3:0]  enc_msg;
    logic [26:0] enc_parity;
    logic        busy;
    logic [15:0] frame_cnt;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [3:0] msg [121];
    logic [5:0] out_q [$];
    int cyc = 0, en_cnt = 0, clr_cnt = 0, stab_err = 0;
    int first_sv = -1, first_mv = -1, first_par = -1, last_msg = -1;
    logic acc_s = 1'b0;
    logic hold_prev = 1'b0;
    logic [5:0] prev_out = '0;

    bch_enc_frame_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .m_is_par   (m_is_par),
        .enc_clr    (enc_clr),
        .enc_en     (enc_en),
        .enc_msg    (enc_msg),
        .enc_parity (enc_parity),
        .busy       (busy),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk = ~clk;

    // Encoder model: serial LFSR division by g(x), four message bits per enable, MSB first.
    logic [26:0] enc_q = '0;
    assign enc_parity = enc_q;

    function automatic logic [26:0] enc_step(input logic [26:0] r, input logic [3:0] d);
        logic [26:0] x;
        logic        fb;
        x = r;
        for (int b = 3; b >= 0; b--) begin
            fb = d[b] ^ x[26];
            x  = {x[25:0], 1'b0} ^ (fb ? GPoly : 27'd0);
        end
        return x;
    endfunction

    always @(posedge clk) begin
        if (enc_clr) enc_q <= '0;
        else if (enc_en) enc_q <= enc_step(enc_q, enc_msg);
    end

    always @(negedge clk) begin
        cyc++;
        acc_s = s_valid & s_ready;
        if (enc_en) en_cnt++;
        if (enc_clr) clr_cnt++;
        if (m_valid && m_ready) out_q.push_back({m_last, m_is_par, m_data});
        if (hold_prev && !(m_valid && {m_last, m_is_par, m_data} == prev_out)) stab_err++;
        hold_prev = m_valid & ~m_ready;
        prev_out  = {m_last, m_is_par, m_data};
        if (first_sv < 0 && s_valid && !busy) first_sv = cyc;
        if (first_mv < 0 && m_valid) first_mv = cyc;
        if (first_par < 0 && m_valid && m_is_par) first_par = cyc;
        if (m_valid && m_ready && !m_is_par) last_msg = cyc;
    end

    function automatic logic [5:0] exp_beat(input int i, input logic [27:0] par);
        int k;
        logic [3:0] d;
        k = i % 128;
        if (k < 121) d = msg[k];
        else d = par[27 - 4*(k-121) -: 4];
        return {k == 127, k >= 121, d};
    endfunction

    task automatic clear_mon();
        out_q.delete();
        en_cnt = 0; clr_cnt = 0; stab_err = 0;
        first_sv = -1; first_mv = -1; first_par = -1; last_msg = -1;
    endtask

    task automatic set_msg(input logic [3:0] last_nib);
        for (int i = 0; i < 121; i++) msg[i] = 4'h0;
        msg[120] = last_nib;
    endtask

    // Drives nfr frames of msg; stops early after stop_acc accepted beats when stop_acc > 0.
    task automatic run_frames(input int nfr, input int sv_pct, input int mr_pct,
                              input int stop_acc, output int beats);
        int idx = 0;
        int n = 0;
        int lim;
        int start;
        logic acc_last = 1'b1;
        lim   = (stop_acc > 0) ? stop_acc : 121 * nfr;
        start = out_q.size();
        while (n < 3000) begin
            if (stop_acc == 0 && out_q.size() - start >= 128 * nfr) break;
            if (stop_acc > 0 && idx >= stop_acc) break;
            if (!(s_valid && !acc_last))
                s_valid = (idx < lim) && ($urandom_range(99) < sv_pct);
            s_data  = s_valid ? msg[idx % 121] : 4'h0;
            m_ready = ($urandom_range(99) < mr_pct);
            @(posedge clk); #1;
            acc_last = acc_s;
            if (acc_s) idx++;
            n++;
        end
        s_valid = 1'b0;
        s_data  = 4'h0;
        beats   = out_q.size() - start;
    endtask

    task automatic test_reset();
        s_valid = 1'b1; s_data = 4'hA; m_ready = 1'b1;
        rst = 1'b1;
        #3 rst = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if ({s_ready, m_valid, enc_en, enc_clr, busy, m_last, m_is_par} !== 7'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got %b want 0000000",
                     {s_ready, m_valid, enc_en, enc_clr, busy, m_last, m_is_par});
        end
        tests_run++;
        if (m_data !== 4'h0) begin
            tests_failed++;
            $display("FAIL reset_m_data: got %h want 0", m_data);
        end
        tests_run++;
        if (frame_cnt !== 16'h0) begin
            tests_failed++;
            $display("FAIL reset_frame_cnt: got %h want 0", frame_cnt);
        end
        @(negedge clk);
        s_valid = 1'b0; m_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_zero_frame();
        int beats;
        set_msg(4'h0);
        clear_mon();
        run_frames(1, 100, 100, 0, beats);
        tests_run++;
        if (beats !== 128) begin
            tests_failed++;
            $display("FAIL zero_beats: got %0d want 128", beats);
        end
        for (int i = 0; i < 128; i++) begin
            if (i < out_q.size()) begin
                tests_run++;
                if (out_q[i] !== exp_beat(i, 28'h0)) begin
                    tests_failed++;
                    $display("FAIL zero_beat%0d: got %h want %h", i, out_q[i], exp_beat(i, 28'h0));
                end
            end
        end
        tests_run++;
        if (frame_cnt !== 16'd1) begin
            tests_failed++;
            $display("FAIL zero_frame_cnt: got %0d want 1", frame_cnt);
        end
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL zero_busy_after: got %b want 0", busy);
        end
    endtask

    task automatic test_parity_vector();
        int beats;
        set_msg(4'h1);
        clear_mon();
        run_frames(1, 100, 100, 0, beats);
        tests_run++;
        if (beats !== 128) begin
            tests_failed++;
            $display("FAIL par_beats: got %0d want 128", beats);
        end
        for (int i = 0; i < 128; i++) begin
            if (i < out_q.size()) begin
                tests_run++;
                if (out_q[i] !== exp_beat(i, ParOne)) begin
                    tests_failed++;
                    $display("FAIL par_beat%0d: got %h want %h", i, out_q[i], exp_beat(i, ParOne));
                end
            end
        end
        tests_run++;
        if (first_mv - first_sv !== 2) begin
            tests_failed++;
            $display("FAIL par_first_latency: got %0d want 2", first_mv - first_sv);
        end
        tests_run++;
        if (first_par - last_msg !== 2) begin
            tests_failed++;
            $display("FAIL par_parity_latency: got %0d want 2", first_par - last_msg);
        end
        tests_run++;
        if (frame_cnt !== 16'd2) begin
            tests_failed++;
            $display("FAIL par_frame_cnt: got %0d want 2", frame_cnt);
        end
    endtask

    task automatic test_random_stall();
        int beats;
        set_msg(4'h1);
        clear_mon();
        run_frames(1, 50, 50, 0, beats);
        tests_run++;
        if (beats !== 128) begin
            tests_failed++;
            $display("FAIL rnd_beats: got %0d want 128", beats);
        end
        for (int i = 0; i < 128; i++) begin
            if (i < out_q.size()) begin
                tests_run++;
                if (out_q[i] !== exp_beat(i, ParOne)) begin
                    tests_failed++;
                    $display("FAIL rnd_beat%0d: got %h want %h", i, out_q[i], exp_beat(i, ParOne));
                end
            end
        end
        tests_run++;
        if (en_cnt !== 121) begin
            tests_failed++;
            $display("FAIL rnd_enc_en_count: got %0d want 121", en_cnt);
        end
        tests_run++;
        if (stab_err !== 0) begin
            tests_failed++;
            $display("FAIL rnd_stall_stability: got %0d unstable cycles want 0", stab_err);
        end
        tests_run++;
        if (frame_cnt !== 16'd3) begin
            tests_failed++;
            $display("FAIL rnd_frame_cnt: got %0d want 3", frame_cnt);
        end
    endtask

    task automatic test_reset_midframe();
        int beats;
        set_msg(4'h1);
        clear_mon();
        run_frames(1, 100, 100, 60, beats);
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_busy_before: got %b want 1", busy);
        end
        s_valid = 1'b1; s_data = 4'hF; m_ready = 1'b1;
        rst = 1'b0;
        #2;
        tests_run++;
        if ({s_ready, m_valid, enc_en, enc_clr, busy, m_last, m_is_par, m_data} !== 11'b0) begin
            tests_failed++;
            $display("FAIL mid_reset_outputs: got %b want 0",
                     {s_ready, m_valid, enc_en, enc_clr, busy, m_last, m_is_par, m_data});
        end
        @(posedge clk); #1;
        tests_run++;
        if ({s_ready, m_valid, enc_en, enc_clr, busy} !== 5'b0) begin
            tests_failed++;
            $display("FAIL mid_reset_held: got %b want 00000",
                     {s_ready, m_valid, enc_en, enc_clr, busy});
        end
        tests_run++;
        if (frame_cnt !== 16'd0) begin
            tests_failed++;
            $display("FAIL mid_reset_frame_cnt: got %0d want 0", frame_cnt);
        end
        @(negedge clk);
        rst = 1'b1; s_valid = 1'b0; m_ready = 1'b0;
        @(posedge clk); #1;
        clear_mon();
        run_frames(1, 100, 100, 0, beats);
        tests_run++;
        if (beats !== 128) begin
            tests_failed++;
            $display("FAIL mid_next_beats: got %0d want 128", beats);
        end
        for (int i = 121; i < 128; i++) begin
            if (i < out_q.size()) begin
                tests_run++;
                if (out_q[i] !== exp_beat(i, ParOne)) begin
                    tests_failed++;
                    $display("FAIL mid_par%0d: got %h want %h", i, out_q[i], exp_beat(i, ParOne));
                end
            end
        end
        tests_run++;
        if (frame_cnt !== 16'd1) begin
            tests_failed++;
            $display("FAIL mid_frame_cnt: got %0d want 1", frame_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int beats;
        set_msg(4'h1);
        clear_mon();
        run_frames(2, 100, 100, 0, beats);
        tests_run++;
        if (beats !== 256) begin
            tests_failed++;
            $display("FAIL b2b_beats: got %0d want 256", beats);
        end
        for (int i = 0; i < 256; i++) begin
            if (i < out_q.size()) begin
                tests_run++;
                if (out_q[i] !== exp_beat(i, ParOne)) begin
                    tests_failed++;
                    $display("FAIL b2b_beat%0d: got %h want %h", i, out_q[i], exp_beat(i, ParOne));
                end
            end
        end
        tests_run++;
        if (clr_cnt !== 2) begin
            tests_failed++;
            $display("FAIL b2b_clr_count: got %0d want 2", clr_cnt);
        end
        tests_run++;
        if (en_cnt !== 242) begin
            tests_failed++;
            $display("FAIL b2b_enc_en_count: got %0d want 242", en_cnt);
        end
        tests_run++;
        if (frame_cnt !== 16'd3) begin
            tests_failed++;
            $display("FAIL b2b_frame_cnt: got %0d want 3", frame_cnt);
        end
    endtask

    task automatic test_wrap();
        int beats;
        set_msg(4'h0);
        clear_mon();
        @(negedge clk);
        force dut.frame_cnt_q = 16'hFFFF;
        @(posedge clk); #1;
        release dut.frame_cnt_q;
        run_frames(1, 100, 100, 0, beats);
        tests_run++;
        if (beats !== 128) begin
            tests_failed++;
            $display("FAIL wrap_beats: got %0d want 128", beats);
        end
        tests_run++;
        if (frame_cnt !== 16'h0000) begin
            tests_failed++;
            $display("FAIL wrap_frame_cnt: got %h want 0000", frame_cnt);
        end
    endtask

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_data = 4'h0; m_ready = 1'b0;
        test_reset();
        test_zero_frame();
        test_parity_vector();
        test_random_stall();
        test_reset_midframe();
        test_back_to_back();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
